// File: rtl/reservation_station_pkg.sv
// Shared widths and opcode encodings for the ALU-side reservation station.
package reservation_station_pkg;

    localparam int unsigned RS_SIZE  = 16;
    localparam int unsigned RS_WID   = 4;
    localparam int unsigned DATA_WID = 32;
    localparam int unsigned ROB_WID  = 4;

    localparam logic [6:0] OPCODE_LUI   = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC = 7'b0010111;
    localparam logic [6:0] OPCODE_JAL   = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR  = 7'b1100111;
    localparam logic [6:0] OPCODE_B     = 7'b1100011;
    localparam logic [6:0] OPCODE_CALI  = 7'b0010011;
    localparam logic [6:0] OPCODE_CAL   = 7'b0110011;

    typedef struct packed {
        logic                rdy;
        logic [DATA_WID-1:0] val;
    } operand_t;

endpackage

// File: rtl/reservation_station_select.sv
// Lowest-index priority encoder: returns the first set bit of vec.
module rs_select #(
    parameter int unsigned N = 16,
    parameter int unsigned W = 4
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         valid
);

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (vec[i] && !valid) begin
                idx   = W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// ALU reservation station: buffers issued ops, snoops ALU/LSB result buses,
// dispatches the lowest-index ready entry one op per cycle.
module reservation_station #(
    parameter int unsigned RS_SIZE = reservation_station_pkg::RS_SIZE,
    parameter int unsigned RS_WID  = reservation_station_pkg::RS_WID,
    parameter int unsigned ROB_W   = reservation_station_pkg::ROB_WID
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             rollback,
    input  logic             issue,
    input  logic             rs_en,
    input  logic [ROB_W-1:0] rob_pos,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             funct7,
    input  logic             rs1_rdy,
    input  logic [31:0]      rs1_val,
    input  logic [ROB_W-1:0] rs1_rob_pos,
    input  logic             rs2_rdy,
    input  logic [31:0]      rs2_val,
    input  logic [ROB_W-1:0] rs2_rob_pos,
    input  logic [31:0]      imm,
    input  logic [31:0]      pc,
    input  logic             alu_done,
    input  logic [31:0]      alu_res,
    input  logic [ROB_W-1:0] alu_res_rob_pos,
    input  logic             lsb_done,
    input  logic [31:0]      lsb_res,
    input  logic [ROB_W-1:0] lsb_res_rob_pos,
    output logic             rs_full,
    output logic             alu_en,
    output logic [6:0]       alu_opcode,
    output logic [2:0]       alu_funct3,
    output logic             alu_funct7,
    output logic [31:0]      alu_val1,
    output logic [31:0]      alu_val2,
    output logic [31:0]      alu_imm,
    output logic [31:0]      alu_pc,
    output logic [ROB_W-1:0] alu_rob_pos
);
    import reservation_station_pkg::*;

    typedef struct packed {
        logic                busy;
        logic [6:0]          opcode;
        logic [2:0]          funct3;
        logic                funct7;
        logic                rdy1;
        logic [DATA_WID-1:0] val1;
        logic [ROB_W-1:0]    q1;
        logic                rdy2;
        logic [DATA_WID-1:0] val2;
        logic [ROB_W-1:0]    q2;
        logic [DATA_WID-1:0] imm;
        logic [DATA_WID-1:0] pc;
        logic [ROB_W-1:0]    rob_pos;
    } entry_t;

    entry_t           ent [RS_SIZE];
    operand_t         w1 [RS_SIZE];
    operand_t         w2 [RS_SIZE];
    entry_t           alloc_ent;
    logic [RS_SIZE-1:0] free_vec;
    logic [RS_SIZE-1:0] ready_vec;
    logic [RS_WID-1:0]  free_idx;
    logic [RS_WID-1:0]  sel_idx;
    logic               free_valid;
    logic               sel_valid;
    logic [RS_WID:0]    free_cnt;

    // Same rule serves wakeup of stored operands and forwarding at allocation.
    function automatic operand_t resolve(input operand_t cur, input logic [ROB_W-1:0] q);
        resolve = cur;
        if (!cur.rdy) begin
            if (alu_done && q == alu_res_rob_pos)
                resolve = {1'b1, alu_res};
            else if (lsb_done && q == lsb_res_rob_pos)
                resolve = {1'b1, lsb_res};
        end
    endfunction

    always_comb begin
        free_cnt = '0;
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            free_vec[i]  = !ent[i].busy;
            ready_vec[i] = ent[i].busy && ent[i].rdy1 && ent[i].rdy2;
            w1[i]        = resolve({ent[i].rdy1, ent[i].val1}, ent[i].q1);
            w2[i]        = resolve({ent[i].rdy2, ent[i].val2}, ent[i].q2);
            free_cnt     = free_cnt + (RS_WID+1)'(free_vec[i]);
        end
    end

    assign rs_full = (free_cnt <= (RS_WID+1)'(1));

    always_comb begin
        operand_t n1;
        operand_t n2;
        n1 = resolve({rs1_rdy, rs1_val}, rs1_rob_pos);
        n2 = resolve({rs2_rdy, rs2_val}, rs2_rob_pos);
        alloc_ent         = '0;
        alloc_ent.busy    = 1'b1;
        alloc_ent.opcode  = opcode;
        alloc_ent.funct3  = funct3;
        alloc_ent.funct7  = funct7;
        alloc_ent.rdy1    = n1.rdy;
        alloc_ent.val1    = n1.val;
        alloc_ent.q1      = rs1_rob_pos;
        alloc_ent.rdy2    = n2.rdy;
        alloc_ent.val2    = n2.val;
        alloc_ent.q2      = rs2_rob_pos;
        alloc_ent.imm     = imm;
        alloc_ent.pc      = pc;
        alloc_ent.rob_pos = rob_pos;
    end

    rs_select #(.N(RS_SIZE), .W(RS_WID)) u_free_sel (
        .vec   (free_vec),
        .idx   (free_idx),
        .valid (free_valid)
    );

    rs_select #(.N(RS_SIZE), .W(RS_WID)) u_ready_sel (
        .vec   (ready_vec),
        .idx   (sel_idx),
        .valid (sel_valid)
    );

    always_ff @(posedge clk) begin
        if (rst || (rdy && rollback)) begin
            for (int unsigned i = 0; i < RS_SIZE; i++)
                ent[i].busy <= 1'b0;
            alu_en      <= 1'b0;
            alu_opcode  <= '0;
            alu_funct3  <= '0;
            alu_funct7  <= 1'b0;
            alu_val1    <= '0;
            alu_val2    <= '0;
            alu_imm     <= '0;
            alu_pc      <= '0;
            alu_rob_pos <= '0;
        end else if (!rdy) begin
            alu_en <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < RS_SIZE; i++) begin
                if (ent[i].busy) begin
                    ent[i].rdy1 <= w1[i].rdy;
                    ent[i].val1 <= w1[i].val;
                    ent[i].rdy2 <= w2[i].rdy;
                    ent[i].val2 <= w2[i].val;
                end
            end
            if (sel_valid) begin
                ent[sel_idx].busy <= 1'b0;
                alu_en      <= 1'b1;
                alu_opcode  <= ent[sel_idx].opcode;
                alu_funct3  <= ent[sel_idx].funct3;
                alu_funct7  <= ent[sel_idx].funct7;
                alu_val1    <= ent[sel_idx].val1;
                alu_val2    <= ent[sel_idx].val2;
                alu_imm     <= ent[sel_idx].imm;
                alu_pc      <= ent[sel_idx].pc;
                alu_rob_pos <= ent[sel_idx].rob_pos;
            end else begin
                alu_en <= 1'b0;
            end
            // Free slot was idle at cycle start, so it never collides with the dispatched one.
            if (issue && rs_en && free_valid)
                ent[free_idx] <= alloc_ent;
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Scoreboard bench for reservation_station: expected dispatches are queued
// at issue time and compared against the observed ALU dispatch stream.
module tb_reservation_station;
    import reservation_station_pkg::*;

    logic        clk = 1'b0;
    logic        rst, rdy, rollback, issue, rs_en;
    logic [3:0]  rob_pos, rs1_rob_pos, rs2_rob_pos, alu_res_rob_pos, lsb_res_rob_pos;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7, rs1_rdy, rs2_rdy, alu_done, lsb_done;
    logic [31:0] rs1_val, rs2_val, imm, pc, alu_res, lsb_res;
    logic        rs_full, alu_en, alu_funct7;
    logic [6:0]  alu_opcode;
    logic [2:0]  alu_funct3;
    logic [31:0] alu_val1, alu_val2, alu_imm, alu_pc;
    logic [3:0]  alu_rob_pos;

    typedef struct packed {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [3:0]  rob;
    } disp_t;

    disp_t exp_q[$];
    disp_t obs_q[$];
    int    obs_cyc[$];
    int    cyc = 0;
    int    checks = 0;
    int    failures = 0;

    reservation_station #(.RS_SIZE(16), .RS_WID(4), .ROB_W(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .issue(issue), .rs_en(rs_en), .rob_pos(rob_pos),
        .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .rs1_rdy(rs1_rdy), .rs1_val(rs1_val), .rs1_rob_pos(rs1_rob_pos),
        .rs2_rdy(rs2_rdy), .rs2_val(rs2_val), .rs2_rob_pos(rs2_rob_pos),
        .imm(imm), .pc(pc),
        .alu_done(alu_done), .alu_res(alu_res), .alu_res_rob_pos(alu_res_rob_pos),
        .lsb_done(lsb_done), .lsb_res(lsb_res), .lsb_res_rob_pos(lsb_res_rob_pos),
        .rs_full(rs_full), .alu_en(alu_en),
        .alu_opcode(alu_opcode), .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
        .alu_val1(alu_val1), .alu_val2(alu_val2), .alu_imm(alu_imm),
        .alu_pc(alu_pc), .alu_rob_pos(alu_rob_pos)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (alu_en === 1'b1) begin
            obs_q.push_back({alu_opcode, alu_funct3, alu_funct7, alu_val1, alu_val2,
                             alu_imm, alu_pc, alu_rob_pos});
            obs_cyc.push_back(cyc);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1);
    end

    function automatic disp_t mk(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                 input logic [31:0] v1, input logic [31:0] v2,
                                 input logic [31:0] im, input logic [31:0] p, input logic [3:0] rob);
        mk = {op, f3, f7, v1, v2, im, p, rob};
    endfunction

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_inputs();
        issue = 1'b0; rs_en = 1'b0; rollback = 1'b0;
        alu_done = 1'b0; lsb_done = 1'b0;
    endtask

    task automatic set_issue(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                             input logic [3:0] rob, input logic r1, input logic [31:0] v1,
                             input logic [3:0] q1, input logic r2, input logic [31:0] v2,
                             input logic [3:0] q2, input logic [31:0] im, input logic [31:0] p);
        issue = 1'b1; rs_en = 1'b1;
        opcode = op; funct3 = f3; funct7 = f7; rob_pos = rob;
        rs1_rdy = r1; rs1_val = v1; rs1_rob_pos = q1;
        rs2_rdy = r2; rs2_val = v2; rs2_rob_pos = q2;
        imm = im; pc = p;
    endtask

    task automatic wait_obs(input int budget);
        for (int n = 0; n < budget && obs_q.size() < exp_q.size(); n++) step();
    endtask

    task automatic flush_queues();
        exp_q.delete(); obs_q.delete(); obs_cyc.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(3);
        checks++;
        if (alu_en !== 1'b0 || rs_full !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl got alu_en=%b rs_full=%b exp 0 0", alu_en, rs_full);
        end
        checks++;
        if ({alu_opcode, alu_funct3, alu_funct7, alu_val1, alu_val2, alu_imm, alu_pc, alu_rob_pos} !== '0) begin
            failures++;
            $display("FAIL reset_fields got val1=%h imm=%h rob=%h exp 0", alu_val1, alu_imm, alu_rob_pos);
        end
        rst = 1'b0;
        step();
        flush_queues();
    endtask

    task automatic test_addi();
        int t0;
        disp_t o, e;
        set_issue(OPCODE_CALI, 3'd0, 1'b0, 4'd3, 1'b1, 32'd5, 4'd0, 1'b1, 32'd0, 4'd0, 32'd7, 32'h100);
        exp_q.push_back(mk(OPCODE_CALI, 3'd0, 1'b0, 32'd5, 32'd0, 32'd7, 32'h100, 4'd3));
        t0 = cyc;
        step(); clear_inputs();
        wait_obs(10);
        checks++;
        if (obs_q.size() != 1) begin
            failures++;
            $display("FAIL addi_count got=%0d exp=1", obs_q.size());
        end else begin
            checks++;
            if (obs_cyc[0] != t0 + 2) begin
                failures++;
                $display("FAIL addi_latency got=%0d exp=%0d", obs_cyc[0] - t0, 2);
            end
            o = obs_q.pop_front(); e = exp_q.pop_front(); void'(obs_cyc.pop_front());
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL addi_data got=%h exp=%h", o, e);
            end
        end
        step(4);
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL addi_freed got=%0d extra dispatches exp=0", obs_q.size());
        end
        flush_queues();
    endtask

    task automatic test_alu_wakeup();
        int t0;
        disp_t o, e;
        set_issue(OPCODE_CAL, 3'd0, 1'b0, 4'd4, 1'b1, 32'd1, 4'd0, 1'b0, 32'd0, 4'd2, 32'd0, 32'h200);
        exp_q.push_back(mk(OPCODE_CAL, 3'd0, 1'b0, 32'd1, 32'h10, 32'd0, 32'h200, 4'd4));
        step(); clear_inputs();
        step(2);
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL wake_early got=%0d dispatches exp=0", obs_q.size());
        end
        alu_done = 1'b1; alu_res_rob_pos = 4'd2; alu_res = 32'h10;
        t0 = cyc;
        step(); clear_inputs();
        wait_obs(10);
        checks++;
        if (obs_q.size() != 1) begin
            failures++;
            $display("FAIL wake_count got=%0d exp=1", obs_q.size());
        end else begin
            checks++;
            if (obs_cyc[0] != t0 + 2) begin
                failures++;
                $display("FAIL wake_latency got=%0d exp=%0d", obs_cyc[0] - t0, 2);
            end
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL wake_data got=%h exp=%h", o, e);
            end
        end
        flush_queues();
    endtask

    task automatic test_lsb_forward();
        int t0;
        disp_t o, e;
        set_issue(OPCODE_CALI, 3'd4, 1'b0, 4'd5, 1'b0, 32'd0, 4'd6, 1'b1, 32'd0, 4'd0, 32'd9, 32'h300);
        lsb_done = 1'b1; lsb_res_rob_pos = 4'd6; lsb_res = 32'hAB;
        exp_q.push_back(mk(OPCODE_CALI, 3'd4, 1'b0, 32'hAB, 32'd0, 32'd9, 32'h300, 4'd5));
        t0 = cyc;
        step(); clear_inputs();
        wait_obs(10);
        checks++;
        if (obs_q.size() != 1) begin
            failures++;
            $display("FAIL fwd_count got=%0d exp=1", obs_q.size());
        end else begin
            checks++;
            if (obs_cyc[0] != t0 + 2) begin
                failures++;
                $display("FAIL fwd_latency got=%0d exp=%0d", obs_cyc[0] - t0, 2);
            end
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL fwd_data got=%h exp=%h", o, e);
            end
        end
        flush_queues();
    endtask

    task automatic test_fill_drain();
        int first;
        disp_t o, e;
        for (int i = 0; i < 15; i++) begin
            set_issue(OPCODE_CAL, 3'd1, 1'b1, 4'(i), 1'b0, 32'd0, 4'd9, 1'b1, 32'(i), 4'd0,
                      32'(i + 100), 32'(i * 4));
            exp_q.push_back(mk(OPCODE_CAL, 3'd1, 1'b1, 32'h99, 32'(i), 32'(i + 100), 32'(i * 4), 4'(i)));
            step(); clear_inputs();
            if (i == 13) begin
                checks++;
                if (rs_full !== 1'b0) begin
                    failures++;
                    $display("FAIL full_at14 got=%b exp=0", rs_full);
                end
            end
        end
        checks++;
        if (rs_full !== 1'b1) begin
            failures++;
            $display("FAIL full_at15 got=%b exp=1", rs_full);
        end
        alu_done = 1'b1; alu_res_rob_pos = 4'd9; alu_res = 32'h99;
        step(); clear_inputs();
        checks++;
        if (rs_full !== 1'b1) begin
            failures++;
            $display("FAIL full_after_wake got=%b exp=1", rs_full);
        end
        step();
        checks++;
        if (rs_full !== 1'b0) begin
            failures++;
            $display("FAIL full_after_first_dispatch got=%b exp=0", rs_full);
        end
        wait_obs(40);
        checks++;
        if (obs_q.size() != 15) begin
            failures++;
            $display("FAIL drain_count got=%0d exp=15", obs_q.size());
        end
        first = (obs_cyc.size() > 0) ? obs_cyc[0] : 0;
        for (int k = 0; k < 15 && obs_q.size() > 0; k++) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL drain_data[%0d] got=%h exp=%h", k, o, e);
            end
            checks++;
            if (obs_cyc[k] != first + k) begin
                failures++;
                $display("FAIL drain_cycle[%0d] got=%0d exp=%0d", k, obs_cyc[k], first + k);
            end
        end
        flush_queues();
    endtask

    task automatic test_rollback();
        for (int i = 0; i < 3; i++) begin
            set_issue(OPCODE_B, 3'd0, 1'b0, 4'(10 + i), 1'b0, 32'd0, 4'd5, 1'b1, 32'd1, 4'd0, 32'd8, 32'h400);
            step(); clear_inputs();
        end
        set_issue(OPCODE_CALI, 3'd0, 1'b0, 4'd13, 1'b1, 32'd1, 4'd0, 1'b1, 32'd2, 4'd0, 32'd3, 32'h500);
        step(); clear_inputs();
        // Rollback lands on the edge that would dispatch rob 13; a new issue and a wakeup arrive too.
        rollback = 1'b1;
        set_issue(OPCODE_CALI, 3'd0, 1'b0, 4'd14, 1'b1, 32'd1, 4'd0, 1'b1, 32'd2, 4'd0, 32'd3, 32'h600);
        alu_done = 1'b1; alu_res_rob_pos = 4'd5; alu_res = 32'h55;
        step(); clear_inputs();
        checks++;
        if (alu_en !== 1'b0 || rs_full !== 1'b0) begin
            failures++;
            $display("FAIL rollback_state got alu_en=%b rs_full=%b exp 0 0", alu_en, rs_full);
        end
        alu_done = 1'b1; alu_res_rob_pos = 4'd5; alu_res = 32'h55;
        step(); clear_inputs();
        step(6);
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL rollback_dispatch got=%0d exp=0", obs_q.size());
        end
        flush_queues();
    endtask

    task automatic test_stall();
        int t0;
        disp_t o, e;
        set_issue(OPCODE_CAL, 3'd2, 1'b0, 4'd7, 1'b0, 32'd0, 4'd1, 1'b1, 32'd2, 4'd0, 32'd0, 32'h700);
        step(); clear_inputs();
        set_issue(OPCODE_CALI, 3'd3, 1'b0, 4'd8, 1'b1, 32'd3, 4'd0, 1'b1, 32'd0, 4'd0, 32'd4, 32'h800);
        step(); clear_inputs();
        rdy = 1'b0;
        alu_done = 1'b1; alu_res_rob_pos = 4'd1; alu_res = 32'h77;
        step(); clear_inputs();
        step(3);
        checks++;
        if (obs_q.size() != 0 || alu_en !== 1'b0) begin
            failures++;
            $display("FAIL stall_dispatch got=%0d alu_en=%b exp=0 0", obs_q.size(), alu_en);
        end
        rdy = 1'b1;
        exp_q.push_back(mk(OPCODE_CALI, 3'd3, 1'b0, 32'd3, 32'd0, 32'd4, 32'h800, 4'd8));
        t0 = cyc;
        step(5);
        checks++;
        if (obs_q.size() != 1) begin
            failures++;
            $display("FAIL resume_count got=%0d exp=1", obs_q.size());
        end else begin
            checks++;
            if (obs_cyc[0] != t0 + 1) begin
                failures++;
                $display("FAIL resume_latency got=%0d exp=1", obs_cyc[0] - t0);
            end
            o = obs_q.pop_front(); e = exp_q.pop_front(); void'(obs_cyc.pop_front());
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL resume_data got=%h exp=%h", o, e);
            end
        end
        flush_queues();
        lsb_done = 1'b1; lsb_res_rob_pos = 4'd1; lsb_res = 32'h55;
        exp_q.push_back(mk(OPCODE_CAL, 3'd2, 1'b0, 32'h55, 32'd2, 32'd0, 32'h700, 4'd7));
        t0 = cyc;
        step(); clear_inputs();
        wait_obs(10);
        checks++;
        if (obs_q.size() != 1) begin
            failures++;
            $display("FAIL late_wake_count got=%0d exp=1", obs_q.size());
        end else begin
            checks++;
            if (obs_cyc[0] != t0 + 2) begin
                failures++;
                $display("FAIL late_wake_latency got=%0d exp=2", obs_cyc[0] - t0);
            end
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL late_wake_data got=%h exp=%h", o, e);
            end
        end
        flush_queues();
    endtask

    task automatic test_reset_midop();
        set_issue(OPCODE_LUI, 3'd0, 1'b0, 4'd2, 1'b1, 32'd0, 4'd0, 1'b1, 32'd0, 4'd0, 32'h1000, 32'h900);
        step(); clear_inputs();
        rst = 1'b1;
        step(); rst = 1'b0;
        checks++;
        if (alu_en !== 1'b0 || alu_imm !== 32'd0) begin
            failures++;
            $display("FAIL midreset_out got alu_en=%b imm=%h exp 0 0", alu_en, alu_imm);
        end
        step(5);
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL midreset_dispatch got=%0d exp=0", obs_q.size());
        end
        flush_queues();
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; rollback = 1'b0; issue = 1'b0; rs_en = 1'b0;
        rob_pos = '0; opcode = '0; funct3 = '0; funct7 = 1'b0;
        rs1_rdy = 1'b0; rs1_val = '0; rs1_rob_pos = '0;
        rs2_rdy = 1'b0; rs2_val = '0; rs2_rob_pos = '0;
        imm = '0; pc = '0;
        alu_done = 1'b0; alu_res = '0; alu_res_rob_pos = '0;
        lsb_done = 1'b0; lsb_res = '0; lsb_res_rob_pos = '0;
        test_reset();
        test_addi();
        test_alu_wakeup();
        test_lsb_forward();
        test_fill_drain();
        test_rollback();
        test_stall();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Receiving end of the decode/issue interface for ALU-class instructions (CAL, CALI, B, LUI, AUIPC, JAL, JALR).
- Buffers issued instructions whose operands may still be pending, snoops the two result buses (ALU, LSB) to wake up operands, and dispatches the oldest-index ready entry to the ALU.
- Sits between the decoder and the ALU in the Tomasulo core.

Parameters:
- RS_SIZE, 16, number of entries.
- RS_WID, 4, log2(RS_SIZE).
- ROB_W, 4, ROB index width (matches ROB_WID in def.v).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- rdy  in  1  global enable; low freezes all state.
- rollback  in  1  mispredict flush.
- issue  in  1  decoder issues this cycle.
- rs_en  in  1  issued instruction targets this block.
- rob_pos  in  ROB_W  destination ROB index.
- opcode  in  7  opcode.
- funct3  in  3  funct3.
- funct7  in  1  inst[30].
- rs1_rdy  in  1  operand 1 valid.
- rs1_val  in  32  operand 1 value.
- rs1_rob_pos  in  ROB_W  producer of operand 1.
- rs2_rdy, rs2_val, rs2_rob_pos  in  1/32/ROB_W  same, for operand 2.
- imm  in  32  immediate.
- pc  in  32  instruction PC.
- alu_done, alu_res, alu_res_rob_pos  in  1/32/ROB_W  ALU result bus.
- lsb_done, lsb_res, lsb_res_rob_pos  in  1/32/ROB_W  LSB result bus.
- rs_full  out  1  fewer than 2 free entries.
- alu_en  out  1  dispatch valid, one cycle.
- alu_opcode  out  7  dispatched opcode.
- alu_funct3  out  3  dispatched funct3.
- alu_funct7  out  1  dispatched funct7.
- alu_val1  out  32  dispatched operand 1.
- alu_val2  out  32  dispatched operand 2.
- alu_imm  out  32  dispatched immediate.
- alu_pc  out  32  dispatched PC.
- alu_rob_pos  out  ROB_W  dispatched ROB index.

Behaviour:
- Per-entry state: busy, opcode, funct3, funct7, rdy1/val1/q1, rdy2/val2/q2, imm, pc, rob_pos.
- Reset (rst=1 at posedge): all busy=0; alu_en=0; all alu_* outputs=0; rs_full=0. Reset mid-operation discards all entries and any pending dispatch.
- Rollback (rdy=1, rollback=1): same clearing as reset. Issue, wakeup and dispatch are ignored that cycle.
- rdy=0: every register holds except alu_en, which is forced to 0.
- Allocation: on issue && rs_en, write the lowest-index entry with busy=0 at cycle start. Set busy=1.
- Same-cycle forwarding on allocation: if rsX_rdy=0 and alu_done && rsX_rob_pos==alu_res_rob_pos, capture alu_res with rdy=1. Else apply the same rule for the LSB bus. ALU takes priority if both match (cannot occur legally).
- Issue with no free entry: drop silently. Upstream honours rs_full, so this is a protocol violation.
- Wakeup: each busy entry with rdyX=0 and qX matching a valid bus captures that value and sets rdyX=1 at the edge. Both operands may wake in the same cycle from different buses.
- Select: the lowest-index entry with busy && rdy1 && rdy2, using state at cycle start. Wakeups in cycle N are visible to select in N+1.
- Dispatch: if a candidate exists, at the edge register alu_en=1 and the alu_* fields from that entry, and clear its busy. Otherwise alu_en=0.
- Latency: an entry allocated at edge E with both operands ready drives alu_en during the cycle after edge E+1 (minimum 2 cycles from issue to ALU input).
- Slot freed by dispatch is reusable from the next cycle; no same-edge alloc/free bypass.
- Allocation and dispatch in the same cycle always touch different entries.
- rs_full: combinational; 1 when free-entry count ≤1. The margin covers the decoder's one-cycle issue latency.
- Operand values for entries whose producer flag was forced ready by the decoder (LUI/JAL etc.) pass through unchanged; no opcode-specific logic here.

Decomposition:
- def.v (shared): RS_SIZE, RS_WID, DATA_WID, ROB_WID, OPCODE_* constants.
- One sub-module, rs_select: parameterised lowest-index priority encoder (vector in, index + valid out). Instantiate twice: free-slot search on ~busy, ready search on busy&rdy1&rdy2.

Test Plan:
- Issue ADDI, rob_pos=3, rs1_rdy=1, val1=5, imm=7 → alu_en=1 two cycles later, alu_val1=5, alu_imm=7, alu_rob_pos=3, entry freed.
- Issue ADD rob_pos=4, rs2 pending on rob 2; ALU bus broadcasts rob 2 value 0x10 three cycles later → dispatch one cycle after broadcast, alu_val2=0x10.
- Issue with rs1 pending on rob 6 while lsb_done, lsb_res_rob_pos=6, lsb_res=0xAB in the same cycle → entry captured ready, dispatch at minimum latency, alu_val1=0xAB.
- Fill 15 entries all pending on rob 9 → rs_full=1 after 15th allocation. Broadcast rob 9 → dispatches in index order 0..14 on consecutive cycles, rs_full drops when ≥2 entries free.
- 3 pending entries, assert rollback → next cycle all busy=0, alu_en=0. Later broadcast of their tags produces no dispatch.
- Hold rdy=0 during a broadcast and ready entries → no dispatch, no wakeup. Resume rdy=1 → state identical to pre-stall, normal dispatch resumes.
